// File: rtl/pe_feeder.sv
// Operand feeder for one SD4 MAC processing element: queues operand sets, issues
// them one at a time with a one-cycle en strobe, waits LAT cycles and returns psum_out.
module pe_feeder #(
  parameter int DEPTH = 4,
  parameter int LAT   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [23:0]              in_image,
  input  logic [35:0]              in_weight,
  input  logic [4:0]               in_exp_bias,
  input  logic [15:0]              in_psum,
  input  logic                     in_chain,
  output logic                     pe_en,
  output logic [23:0]              pe_image,
  output logic [35:0]              pe_weight,
  output logic [4:0]               pe_exp_bias,
  output logic [15:0]              pe_psum,
  input  logic [15:0]              pe_psum_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_psum,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(LAT + 1);

  typedef struct packed {
    logic [23:0] image;
    logic [35:0] weight;
    logic [4:0]  exp_bias;
    logic [15:0] psum;
    logic        chain;
  } entry_t;

  typedef struct packed {
    logic [23:0] image;
    logic [35:0] weight;
    logic [4:0]  exp_bias;
    logic [15:0] psum;
  } ops_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  entry_t          in_entry;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            full;
  logic            push;
  logic            pop;

  state_t          state_q, state_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  ops_t            ops_q, ops_d;
  logic            pe_en_q, pe_en_d;
  logic            out_valid_q, out_valid_d;
  logic [15:0]     out_psum_q, out_psum_d;
  logic [15:0]     acc_q, acc_d;

  assign in_entry = '{image: in_image, weight: in_weight, exp_bias: in_exp_bias,
                      psum: in_psum, chain: in_chain};
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign in_ready = ~rst & ~full;
  assign push     = in_valid & in_ready;
  assign head     = mem[rd_ptr_q];

  // NOTE: storage array carries no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      ops_q       <= '0;
      pe_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_psum_q  <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      ops_q       <= ops_d;
      pe_en_q     <= pe_en_d;
      out_valid_q <= out_valid_d;
      out_psum_q  <= out_psum_d;
      acc_q       <= acc_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    ops_d       = ops_q;
    pe_en_d     = 1'b0;
    out_valid_d = out_valid_q;
    out_psum_d  = out_psum_q;
    acc_d       = acc_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop            = 1'b1;
          ops_d.image    = head.image;
          ops_d.weight   = head.weight;
          ops_d.exp_bias = head.exp_bias;
          ops_d.psum     = head.chain ? acc_q : head.psum;
          pe_en_d        = 1'b1;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wcnt_d  = WW'(LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == '0) begin
          out_psum_d  = pe_psum_out;
          acc_d       = pe_psum_out;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          wcnt_d = wcnt_q - WW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pe_en       = pe_en_q;
  assign pe_image    = ops_q.image;
  assign pe_weight   = ops_q.weight;
  assign pe_exp_bias = ops_q.exp_bias;
  assign pe_psum     = ops_q.psum;
  assign out_valid   = out_valid_q;
  assign out_psum    = out_psum_q;
  assign count       = count_q;
  assign busy        = (state_q != S_IDLE) | (count_q != '0);

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder with a LAT-stage stub PE that returns psum + stub_add.
module tb_pe_feeder;
  localparam int DEPTH = 4;
  localparam int LAT   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [23:0] in_image;
  logic [35:0] in_weight;
  logic [4:0]  in_exp_bias;
  logic [15:0] in_psum;
  logic        in_chain;
  logic        pe_en;
  logic [23:0] pe_image;
  logic [35:0] pe_weight;
  logic [4:0]  pe_exp_bias;
  logic [15:0] pe_psum, pe_psum_out;
  logic        out_valid, out_ready;
  logic [15:0] out_psum;
  logic        busy;
  logic [$clog2(DEPTH):0] count;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [15:0] stub_add = 16'h0001;
  logic [15:0] pipe [LAT];

  pe_feeder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_image(in_image), .in_weight(in_weight), .in_exp_bias(in_exp_bias),
    .in_psum(in_psum), .in_chain(in_chain),
    .pe_en(pe_en), .pe_image(pe_image), .pe_weight(pe_weight),
    .pe_exp_bias(pe_exp_bias), .pe_psum(pe_psum), .pe_psum_out(pe_psum_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stub PE: result is valid only in the cycle before the feeder's capture edge.
  always @(posedge clk) begin
    pipe[0] <= pe_en ? (pe_psum + stub_add) : 16'hDEAD;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign pe_psum_out = pipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [15:0] ps, input logic ch);
    in_valid    = v;
    in_image    = {8'hA5, ps};
    in_weight   = {20'h12345, ps};
    in_exp_bias = ps[4:0];
    in_psum     = ps;
    in_chain    = ch;
  endtask

  task automatic push(input logic [15:0] ps, input logic ch);
    set_in(1'b1, ps, ch);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [15:0] exp);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check(tag, out_psum, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int          e0, rise, en_hi, ok;
    logic [5:0]  rdy;
    logic [15:0] held;

    rst = 1'b1;
    out_ready = 1'b0;
    set_in(1'b0, 16'h0000, 1'b0);
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_pe_en", pe_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_out_psum", out_psum, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // Single operation
    in_valid = 1'b1; in_image = 24'hFFFFFF; in_weight = 36'h9C366C17E;
    in_exp_bias = 5'b11110; in_psum = 16'h000F; in_chain = 1'b0;
    tick();
    in_valid = 1'b0;
    e0 = cyc;
    check("single_count_e0", count, 1);
    check("single_en_e0", pe_en, 0);
    tick();
    check("single_en_e1", pe_en, 1);
    check("single_count_e1", count, 0);
    check("single_image", pe_image, 24'hFFFFFF);
    check("single_weight", pe_weight, 36'h9C366C17E);
    check("single_bias", pe_exp_bias, 5'b11110);
    check("single_psum", pe_psum, 16'h000F);
    en_hi = 1; ok = 1; rise = -1;
    for (int i = 0; i < 20 && rise < 0; i++) begin
      tick();
      if (pe_en) en_hi++;
      if (pe_image !== 24'hFFFFFF || pe_weight !== 36'h9C366C17E ||
          pe_exp_bias !== 5'b11110 || pe_psum !== 16'h000F) ok = 0;
      if (out_valid) rise = cyc;
    end
    check("single_en_cycles", en_hi, 1);
    check("single_ops_stable", ok, 1);
    check("single_rise_edge", rise, e0 + 6);
    check("single_out_psum", out_psum, 16'h0010);
    check("single_busy_done", busy, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_hs_valid", out_valid, 0);
    check("single_idle_busy", busy, 0);

    // Fill: out_ready low, six back-to-back offers
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 16'h0100 + 16'(i), 1'b0);
      rdy[i] = in_ready;
      tick();
    end
    check("fill_ready_pattern", rdy, 6'b011111);
    check("fill_count", count, 4);
    check("fill_in_ready", in_ready, 0);
    get_result("fill_r0", 16'h0101);
    // Full simultaneous: 6th set (psum 0105) still offered; handshake done above
    check("full_hs_count", count, 4);
    check("full_hs_in_ready", in_ready, 0);
    check("full_hs_pe_en", pe_en, 0);
    tick();
    check("full_pop_count", count, 3);
    check("full_pop_pe_en", pe_en, 1);
    check("full_pop_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("full_push_count", count, 4);
    check("full_push_in_ready", in_ready, 0);

    // Back-pressure on result 0102 with FIFO non-empty
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    check("bp_valid", out_valid, 1);
    held = out_psum;
    check("bp_psum", held, 16'h0102);
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pe_en || !out_valid || out_psum !== held) ok = 0;
    end
    check("bp_held", ok, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_hs_pe_en", pe_en, 0);
    tick();
    check("bp_next_issue", pe_en, 1);
    get_result("drain_r2", 16'h0103);
    get_result("drain_r3", 16'h0104);
    get_result("drain_r4", 16'h0105);
    get_result("drain_r5", 16'h0106);
    check("drain_busy", busy, 0);

    // Chaining
    stub_add = 16'h0100;
    push(16'h00FF, 1'b0);
    push(16'h1234, 1'b1);
    push(16'h5678, 1'b1);
    get_result("chain_r0", 16'h01FF);
    get_result("chain_r1", 16'h02FF);
    get_result("chain_r2", 16'h03FF);

    // Reset during WAIT with two entries queued
    push(16'h0001, 1'b0);
    push(16'h0002, 1'b0);
    push(16'h0003, 1'b0);
    tick();
    check("mid_count_before", count, 2);
    rst = 1'b1;
    #1;
    check("mid_rst_pe_en", pe_en, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pe_psum", pe_psum, 0);
    tick();
    rst = 1'b0;
    tick();
    check("mid_rel_in_ready", in_ready, 1);
    out_ready = 1'b1;
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pe_en || out_valid || count != 0) ok = 0;
    end
    out_ready = 1'b0;
    check("mid_no_output", ok, 1);

    // Accumulator cleared by reset: chained entry sees psum 0
    push(16'hBEEF, 1'b1);
    get_result("acc_after_rst", 16'h0100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_feeder.md
# pe_feeder

Initiator for the SD4 MAC processing-element operand interface. Buffers complete operand sets (image, SD4 weight word, exponent bias, partial sum) in a small FIFO and issues them one at a time to a PE by driving the one-cycle `en` strobe with stable operands. It waits a fixed PE latency, captures `psum_out`, and returns the result on a valid/ready output. Optional chaining feeds the previous result back as the next partial sum. It sits between the layer controller/buffers and each PE instance.

## Interface
- `DEPTH`, 4: operand FIFO entries (power of two, ≥2).
- `LAT`, 4: cycles after the PE samples `en` high until `psum_out` is valid (≥1).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `in_valid` input 1: operand set offered.
- `in_ready` output 1: `!full`; 0 while `rst` is high.
- `in_image` input 24: activation word.
- `in_weight` input 36: SD4-encoded weight word.
- `in_exp_bias` input 5: exponent bias.
- `in_psum` input 16: partial sum, used when `in_chain`=0.
- `in_chain` input 1: 1 = use the last captured result as psum.
- `pe_en` output 1: issue strobe to the PE.
- `pe_image` output 24, `pe_weight` output 36, `pe_exp_bias` output 5, `pe_psum` output 16: registered operands to the PE.
- `pe_psum_out` input 16: PE result.
- `out_valid` output 1, `out_ready` input 1, `out_psum` output 16: result handshake.
- `busy` output 1: state ≠ IDLE or FIFO non-empty.
- `count` output $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- FIFO entry is 82 bits: image, weight, exp_bias, psum, chain. A push occurs when `in_valid && in_ready`.
- FSM states:
  - **IDLE**: if the FIFO is non-empty, load the `pe_*` registers from the head, pop, set `pe_en`<=1, go to ISSUE.
  - **ISSUE**: `pe_en`<=0, load `wcnt`<=LAT-1, go to WAIT.
  - **WAIT**: decrement `wcnt`. At the edge where `wcnt`==0, capture `pe_psum_out` into `out_psum` and `acc`, set `out_valid`<=1, go to DONE.
  - **DONE**: on `out_valid && out_ready`, clear `out_valid` and go to IDLE.
- Chaining: `pe_psum` takes `acc` if the head entry's chain bit is 1, otherwise the entry's psum. `acc` is 0 after reset.
- `pe_*` operands hold their values from the issue load until the next issue load. They never change during ISSUE, WAIT or DONE.
- Pushes continue in every state. Only IDLE pops.
- Push and pop in the same edge: `count` is unchanged.
- Pointers wrap modulo DEPTH. At full, `in_ready`=0 and no push is accepted. Popping while full raises `in_ready` on the next cycle, not in the same cycle.
- No arithmetic is performed on psum. The width is 16 bits throughout.
- Reset (at any time, including mid-WAIT or DONE) forces:
  - `pe_en`=0, all `pe_*`=0, `out_valid`=0, `out_psum`=0, `acc`=0;
  - FIFO empty, `count`=0, state IDLE, `busy`=0.
  - Queued entries are discarded.

## Timing
- Push accepted at edge E0 into an empty FIFO while IDLE: issue load at edge E1, and `pe_en` is high for exactly the cycle E1–E2.
- The PE samples `en` at E2. The feeder captures at edge E2+LAT-1+1 = E1+LAT+1, so `out_valid` rises after edge E0+LAT+2.
- With `out_ready` held at 1, the handshake occurs at the next edge and the next issue follows one edge later. Steady-state throughput is one operation per LAT+3 cycles.
- `out_valid` and `out_psum` stay stable until the handshake. There is no combinational path from `out_ready` or `in_valid` to any output.

## Test plan
- **Reset:** pulse `rst` during WAIT with 2 entries queued. Required: `pe_en`=0, `out_valid`=0, `count`=0, `in_ready`=1 one cycle after release, and no later output.
- **Single operation:** push image=24'hFFFFFF, weight=36'h9C366C17E, exp_bias=5'b11110, psum=16'h000F, with a stub PE where `psum_out`=psum+1 after LAT. Required:
  - `pe_en` high for exactly 1 cycle;
  - operands stable through capture;
  - `out_psum`=16'h0010 with `out_valid` rising after edge E0+6 (LAT=4).
- **Fill:** `out_ready`=0, push 6 sets back-to-back. Required: 5 accepted (1 issued, 4 queued), `in_ready`=0 on the 6th, and `count`=4.
- **Chaining:** stub adds 16'h0100. Push psum=16'h00FF with chain=0, then two sets with chain=1. Required outputs: 16'h01FF, 16'h02FF, 16'h03FF.
- **Back-pressure:** hold `out_ready`=0 for 10 cycles in DONE with the FIFO non-empty. Required: `out_psum` held, `pe_en`=0 throughout, and the next issue exactly 1 edge after the handshake.
- **Full simultaneous:** with the FIFO full and `in_valid`=1 held while IDLE pops. Required: no push in the pop cycle, push on the following edge, and `count` returns to DEPTH.
